// File: rtl/btn_conditioner.sv
// Per-lane button conditioner: 2-flop sync, debounce, press/release pulses,
// long-hold pulse and press-toggled state. All outputs registered.
module btn_conditioner #(
    parameter int   NUM_BTN         = 2,
    parameter int   DEBOUNCE_CYCLES = 1000000,
    parameter int   HOLD_CYCLES     = 65536,
    parameter logic TOGGLE_INIT     = 1'b1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_BTN-1:0] btn_raw,
    output logic [NUM_BTN-1:0] btn_level,
    output logic [NUM_BTN-1:0] btn_press,
    output logic [NUM_BTN-1:0] btn_release,
    output logic [NUM_BTN-1:0] btn_hold,
    output logic [NUM_BTN-1:0] btn_toggle
);

    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int HW = $clog2(HOLD_CYCLES + 1);
    localparam logic [DW-1:0] DEB_LAST = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD_CYCLES);

    function automatic logic [HW-1:0] hold_sat_inc(input logic [HW-1:0] cnt);
        return (cnt == HOLD_MAX) ? cnt : cnt + 1'b1;
    endfunction

    logic [NUM_BTN-1:0] s1_q, s1_d;
    logic [NUM_BTN-1:0] s2_q, s2_d;
    logic [NUM_BTN-1:0] level_q, level_d;
    logic [NUM_BTN-1:0] press_q, press_d;
    logic [NUM_BTN-1:0] release_q, release_d;
    logic [NUM_BTN-1:0] hold_q, hold_d;
    logic [NUM_BTN-1:0] fired_q, fired_d;
    logic [NUM_BTN-1:0] toggle_q, toggle_d;
    logic [DW-1:0]      deb_cnt_q  [NUM_BTN];
    logic [DW-1:0]      deb_cnt_d  [NUM_BTN];
    logic [HW-1:0]      hold_cnt_q [NUM_BTN];
    logic [HW-1:0]      hold_cnt_d [NUM_BTN];

    always_comb begin
        s1_d       = btn_raw;
        s2_d       = s1_q;
        level_d    = level_q;
        hold_d     = '0;
        fired_d    = '0;
        deb_cnt_d  = deb_cnt_q;
        hold_cnt_d = hold_cnt_q;
        for (int i = 0; i < NUM_BTN; i++) begin
            // Count only while the synced input disagrees with the accepted level;
            // any agreement (bounce back) restarts the count.
            deb_cnt_d[i] = '0;
            if (s2_q[i] != level_q[i]) begin
                if (deb_cnt_q[i] == DEB_LAST) begin
                    level_d[i] = s2_q[i];
                end else begin
                    deb_cnt_d[i] = deb_cnt_q[i] + 1'b1;
                end
            end
            hold_cnt_d[i] = level_q[i] ? hold_sat_inc(hold_cnt_q[i]) : '0;
            hold_d[i]     = level_q[i] & ~fired_q[i] & (hold_cnt_d[i] == HOLD_MAX);
            // Fired flag keeps the saturated count from re-pulsing until release.
            fired_d[i]    = level_q[i] & (fired_q[i] | hold_d[i]);
        end
        press_d   = level_d & ~level_q;
        release_d = ~level_d & level_q;
        toggle_d  = toggle_q ^ press_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_q       <= '0;
            s2_q       <= '0;
            level_q    <= '0;
            press_q    <= '0;
            release_q  <= '0;
            hold_q     <= '0;
            fired_q    <= '0;
            toggle_q   <= {NUM_BTN{TOGGLE_INIT}};
            deb_cnt_q  <= '{default: '0};
            hold_cnt_q <= '{default: '0};
        end else begin
            s1_q       <= s1_d;
            s2_q       <= s2_d;
            level_q    <= level_d;
            press_q    <= press_d;
            release_q  <= release_d;
            hold_q     <= hold_d;
            fired_q    <= fired_d;
            toggle_q   <= toggle_d;
            deb_cnt_q  <= deb_cnt_d;
            hold_cnt_q <= hold_cnt_d;
        end
    end

    assign btn_level   = level_q;
    assign btn_press   = press_q;
    assign btn_release = release_q;
    assign btn_hold    = hold_q;
    assign btn_toggle  = toggle_q;

endmodule

// File: tb/tb_btn_conditioner.sv
// Bench for btn_conditioner: directed button stimulus with an event scoreboard
// keyed on the cycle in which each press/release/hold pulse must appear.
module tb_btn_conditioner;

    localparam int NB   = 2;
    localparam int DEB  = 4;
    localparam int HOLD = 10;

    typedef struct {
        int         cyc;
        logic [1:0] press;
        logic [1:0] rel;
        logic [1:0] hold;
        logic [1:0] lvl;
        logic [1:0] tog;
    } ev_t;

    logic          clk = 1'b0;
    logic          reset;
    logic [NB-1:0] btn_raw;
    logic [NB-1:0] btn_level;
    logic [NB-1:0] btn_press;
    logic [NB-1:0] btn_release;
    logic [NB-1:0] btn_hold;
    logic [NB-1:0] btn_toggle;

    int  cyc     = 0;
    int  n_tests = 0;
    int  n_fail  = 0;
    ev_t exp_q[$];
    ev_t mon_e;
    bit  bounce_pat [7] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};

    btn_conditioner #(
        .NUM_BTN        (NB),
        .DEBOUNCE_CYCLES(DEB),
        .HOLD_CYCLES    (HOLD),
        .TOGGLE_INIT    (1'b1)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .btn_raw    (btn_raw),
        .btn_level  (btn_level),
        .btn_press  (btn_press),
        .btn_release(btn_release),
        .btn_hold   (btn_hold),
        .btn_toggle (btn_toggle)
    );

    always #5 clk = ~clk;

    // cyc == n while sampling the cycle that follows posedge number n
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cyc %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic push(input int c, input logic [1:0] p, input logic [1:0] r,
                        input logic [1:0] h, input logic [1:0] l, input logic [1:0] t);
        ev_t e;
        e.cyc = c; e.press = p; e.rel = r; e.hold = h; e.lvl = l; e.tog = t;
        exp_q.push_back(e);
    endtask

    task automatic wait_until(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    // Monitor: every pulse the DUT shows must match the next expected event.
    always @(negedge clk) begin
        if ((btn_press | btn_release | btn_hold) != 2'b00) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_event at cyc %0d: press=%b release=%b hold=%b, none expected",
                         cyc, btn_press, btn_release, btn_hold);
            end else begin
                mon_e = exp_q.pop_front();
                chk("ev_cycle",   cyc,         mon_e.cyc);
                chk("ev_press",   btn_press,   mon_e.press);
                chk("ev_release", btn_release, mon_e.rel);
                chk("ev_hold",    btn_hold,    mon_e.hold);
                chk("ev_level",   btn_level,   mon_e.lvl);
                chk("ev_toggle",  btn_toggle,  mon_e.tog);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        int t4;
        reset   = 1'b1;
        btn_raw = 2'b00;

        // Reset state
        @(negedge clk);
        chk("rst_level",   btn_level,   2'b00);
        chk("rst_press",   btn_press,   2'b00);
        chk("rst_release", btn_release, 2'b00);
        chk("rst_hold",    btn_hold,    2'b00);
        chk("rst_toggle",  btn_toggle,  2'b11);

        // Clean press on lane 0, held 30 cycles: one press, one hold, one release
        wait_until(3);
        reset   = 1'b0;
        btn_raw = 2'b01;
        t = cyc;
        push(t + 6,  2'b01, 2'b00, 2'b00, 2'b01, 2'b10);
        push(t + 16, 2'b00, 2'b00, 2'b01, 2'b01, 2'b10);
        wait_until(t + 36);
        btn_raw = 2'b00;
        t = cyc;
        push(t + 6, 2'b00, 2'b01, 2'b00, 2'b00, 2'b10);

        // Glitch of 3 cycles must be ignored
        wait_until(t + 10);
        btn_raw = 2'b01;
        repeat (3) @(negedge clk);
        btn_raw = 2'b00;
        repeat (20) @(negedge clk);
        chk("glitch_level",  btn_level,  2'b00);
        chk("glitch_toggle", btn_toggle, 2'b10);

        // Bounce then stable high; held 15 cycles past press -> second hold
        for (int i = 0; i < 7; i++) begin
            btn_raw = {1'b0, bounce_pat[i]};
            @(negedge clk);
        end
        btn_raw = 2'b01;
        t = cyc;
        push(t + 6,  2'b01, 2'b00, 2'b00, 2'b01, 2'b11);
        push(t + 16, 2'b00, 2'b00, 2'b01, 2'b01, 2'b11);
        wait_until(t + 21);
        btn_raw = 2'b00;
        t = cyc;
        push(t + 6, 2'b00, 2'b01, 2'b00, 2'b00, 2'b11);

        // Reset while the hold count is 5, button kept pressed through it
        wait_until(t + 10);
        btn_raw = 2'b01;
        t = cyc;
        push(t + 6, 2'b01, 2'b00, 2'b00, 2'b01, 2'b10);
        wait_until(t + 11);
        reset = 1'b1;
        @(negedge clk);
        chk("midrst_level",   btn_level,   2'b00);
        chk("midrst_press",   btn_press,   2'b00);
        chk("midrst_release", btn_release, 2'b00);
        chk("midrst_hold",    btn_hold,    2'b00);
        chk("midrst_toggle",  btn_toggle,  2'b11);
        reset = 1'b0;
        t = cyc;
        push(t + 6,  2'b01, 2'b00, 2'b00, 2'b01, 2'b10);
        push(t + 16, 2'b00, 2'b00, 2'b01, 2'b01, 2'b10);
        wait_until(t + 20);
        btn_raw = 2'b00;
        t = cyc;
        push(t + 6, 2'b00, 2'b01, 2'b00, 2'b00, 2'b10);

        // Both lanes together; lane 1 released early (no hold), lane 0 holds
        wait_until(t + 10);
        btn_raw = 2'b11;
        t = cyc;
        push(t + 6, 2'b11, 2'b00, 2'b00, 2'b11, 2'b01);
        wait_until(t + 8);
        btn_raw = 2'b01;
        t4 = cyc;
        push(t4 + 6, 2'b00, 2'b10, 2'b00, 2'b01, 2'b01);
        push(t + 16, 2'b00, 2'b00, 2'b01, 2'b01, 2'b01);
        wait_until(t + 20);
        btn_raw = 2'b00;
        t = cyc;
        push(t + 6, 2'b00, 2'b01, 2'b00, 2'b00, 2'b01);

        wait_until(t + 12);
        chk("final_level",    btn_level,     2'b00);
        chk("pending_events", exp_q.size(),  0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/btn_conditioner.md
Name: btn_conditioner

Overview:
- Input-side counterpart to the display path: turns raw, asynchronous, bouncing board buttons into clean, clock-aligned control events for the stopwatch core.
- Per button it synchronises and debounces the input, then produces:
  - a stable level;
  - one-cycle press and release pulses;
  - a long-hold pulse;
  - a press-toggled state.
- Top-level replaces its ad-hoc hold counter (reset) and level-sampled pause toggle with this block's `btn_hold` and `btn_toggle` outputs.

Parameters:
- NUM_BTN, 2, number of independent button lanes (must be >= 1).
- DEBOUNCE_CYCLES, 1000000, consecutive stable clk cycles required to accept a level change (10 ms at 100 MHz; must be >= 1).
- HOLD_CYCLES, 65536, clk cycles the debounced level must stay high before `btn_hold` fires (must be >= 1).
- TOGGLE_INIT, 1'b1, value of every `btn_toggle` bit after reset (pause toggle starts "running").

Ports:
- clk  input  1  100 MHz master clock
- reset  input  1  synchronous, active-high reset
- btn_raw  input  NUM_BTN  raw asynchronous button inputs, active-high
- btn_level  output  NUM_BTN  debounced button level
- btn_press  output  NUM_BTN  one-cycle pulse on accepted rising level
- btn_release  output  NUM_BTN  one-cycle pulse on accepted falling level
- btn_hold  output  NUM_BTN  one-cycle pulse when level has been high HOLD_CYCLES cycles
- btn_toggle  output  NUM_BTN  flips on every `btn_press`

Behaviour:
- Lanes are fully independent; all logic is replicated per bit. No cross-lane interaction.
- Reset (synchronous, sampled high at a clk edge) has priority over all other logic. On that edge:
  - sync stages, debounce counter, hold counter and hold-fired flag are cleared;
  - `btn_level`, `btn_press`, `btn_release` and `btn_hold` go to 0;
  - `btn_toggle` goes to TOGGLE_INIT.
- Synchroniser: 2-flop chain, `s1` <= `btn_raw`, `s2` <= `s1`. No other logic reads `btn_raw`.
- Debounce, evaluated each edge:
  - If `s2` == `btn_level`, the debounce counter clears.
  - Otherwise the counter increments.
  - On the edge where the counter would reach DEBOUNCE_CYCLES, `btn_level` <= `s2` and the counter clears.
  - Counter width is `$clog2(DEBOUNCE_CYCLES+1)`; it never wraps.
- Latency: if `btn_raw` changes before edge 1 and stays stable, `btn_level` changes at edge DEBOUNCE_CYCLES+2.
- Bounce handling: any reversion of `s2` to the current level before the count completes restarts the count from 0. A pulse shorter than DEBOUNCE_CYCLES cycles (after sync) never changes `btn_level`.
- Edge pulses:
  - `btn_press` is registered and is high during exactly the first cycle in which `btn_level` reads 1.
  - `btn_release` behaves the same for the first cycle in which `btn_level` reads 0.
  - Neither pulse is ever high for 2 consecutive cycles.
- Toggle: `btn_toggle` flips on the same edge that raises `btn_press`, so the new value is visible in the pulse cycle.
- Hold detection:
  - The hold counter clears while `btn_level`=0 and increments while `btn_level`=1.
  - It saturates at HOLD_CYCLES; width is `$clog2(HOLD_CYCLES+1)`.
  - `btn_hold` pulses for exactly one cycle, HOLD_CYCLES cycles after the `btn_press` cycle, i.e. the cycle where the count first equals HOLD_CYCLES.
  - It fires at most once per press. It re-arms only after `btn_level` returns to 0.
- Release before HOLD_CYCLES: no `btn_hold`; the counter clears; `btn_release` fires normally.
- Button held through reset:
  - After reset deasserts, `btn_level` rises after the normal DEBOUNCE_CYCLES+2 latency.
  - `btn_press` fires and `btn_toggle` flips.
  - A reset held by a hold-derived reset therefore does not suppress the post-reset press; the top level handles this.
- No combinational path from `btn_raw` to any output. All outputs are registered.

Test Plan:
(NUM_BTN=2, DEBOUNCE_CYCLES=4, HOLD_CYCLES=10, TOGGLE_INIT=1; reset for 3 cycles, then released.)
- Clean press: `btn_raw`[0] 0->1 before edge 1, held -> `btn_level`[0]=1 from edge 6; `btn_press`[0]=1 for exactly that cycle; `btn_toggle`[0] 1->0 at edge 6; lane 1 outputs stay 0/1.
- Glitch rejection: `btn_raw`[0] high for 3 cycles then low -> `btn_level`, `btn_press`, `btn_toggle` unchanged for 20 cycles.
- Bounce: `btn_raw`[0] pattern 1,1,0,0,1,1,0 then stable 1 -> exactly one `btn_press`[0], at 6 edges after the final 0->1 sample; no `btn_release`.
- Long hold: hold `btn_raw`[0]=1 for 30 cycles past the press -> `btn_hold`[0] pulses once, 10 cycles after the `btn_press` cycle, and never again. Release -> `btn_release`[0] one cycle. Press again for 15 cycles -> second `btn_hold`.
- Reset mid-hold: assert reset when the hold count is 5 with `btn_raw`[0]=1 -> on the next edge all outputs are 0 and `btn_toggle`=2'b11. Deassert with the button still held -> `btn_press`[0] at edge 6 after release; `btn_hold`[0] 10 cycles later.
- Simultaneous lanes: `btn_raw`=2'b11 at once -> `btn_press`=2'b11 in the same cycle; both toggles flip; independent `btn_release` when lane 1 drops alone.
